bridge_router_pipe: RTL and testbench

//  Parametrised, registered successor to the bridge address fan-out: routes host bridge

---
 rtl/bridge_router_pkg.sv | 32 +++
 rtl/bridge_router_pipe_if.sv | 22 ++
 rtl/bridge_range_decode.sv | 35 +++
 rtl/bridge_router_pipe.sv | 152 +++++++++++++++
 tb/tb_bridge_router_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_router_pkg.sv
// Shared types and range helpers for the bridge router: FSM states, address range
// records and the slicer that pulls one leaf's range out of the packed parameter vectors.
package bridge_router_pkg;

  localparam int MAX_LEAVES  = 16;
  localparam int MAX_ADDR_W  = 64;
  localparam int RANGE_VEC_W = MAX_LEAVES * MAX_ADDR_W;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } rd_state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] from_addr;
    logic [MAX_ADDR_W-1:0] to_addr;
  } addr_range_t;

  // Ranges come back zero-extended to MAX_ADDR_W, so unsigned compares stay exact.
  function automatic addr_range_t unpack_range(input logic [RANGE_VEC_W-1:0] from_vec,
                                               input logic [RANGE_VEC_W-1:0] to_vec,
                                               input int unsigned           addr_w,
                                               input int unsigned           idx);
    addr_range_t           r;
    logic [MAX_ADDR_W-1:0] mask;
    mask        = {MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - addr_w);
    r.from_addr = MAX_ADDR_W'(from_vec >> (idx * addr_w)) & mask;
    r.to_addr   = MAX_ADDR_W'(to_vec >> (idx * addr_w)) & mask;
    return r;
  endfunction

endpackage

// File: rtl/bridge_router_pipe_if.sv
// Host-side APF bridge bus seen by the router: address, write/read strobes, data and endianness.
interface bridge_router_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] bridge_addr;
  logic              bridge_wr;
  logic [DATA_W-1:0] bridge_wr_data;
  logic              bridge_rd;
  logic [DATA_W-1:0] bridge_rd_data;
  logic              bridge_endian_little;

  modport master (
    output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
    input  bridge_rd_data, bridge_endian_little
  );

  modport slave (
    input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
    output bridge_rd_data, bridge_endian_little
  );
endinterface

// File: rtl/bridge_range_decode.sv
// Combinational priority address decoder: the lowest-index leaf whose inclusive range
// contains addr wins.
module bridge_range_decode
  import bridge_router_pkg::*;
#(
  parameter int                          NUM_LEAVES = 6,
  parameter int                          ADDR_W     = 32,
  parameter int                          SEL_W      = 3,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] FROM_ADDRS = '0,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] TO_ADDRS   = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);
  localparam logic [RANGE_VEC_W-1:0] FROM_VEC = RANGE_VEC_W'(FROM_ADDRS);
  localparam logic [RANGE_VEC_W-1:0] TO_VEC   = RANGE_VEC_W'(TO_ADDRS);

  always_comb begin
    addr_range_t           rng;
    logic [MAX_ADDR_W-1:0] addr_ext;
    hit      = 1'b0;
    sel      = '0;
    rng      = '0;
    addr_ext = MAX_ADDR_W'(addr);
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      rng = unpack_range(FROM_VEC, TO_VEC, ADDR_W, i);
      if ((addr_ext >= rng.from_addr) && (addr_ext <= rng.to_addr)) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/bridge_router_pipe.sv
// Registered bridge-to-leaf router with a read-return FSM and miss/overrun accounting.
// Define BRIDGE_ROUTER_TIMEOUT_EN to add the RD_WAIT watchdog and timeout_count.
module bridge_router_pipe
  import bridge_router_pkg::*;
#(
  parameter int                          NUM_LEAVES      = 6,
  parameter int                          ADDR_W          = 32,
  parameter int                          DATA_W          = 32,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] FROM_ADDRS      = '0,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] TO_ADDRS        = '1,
  parameter logic [DATA_W-1:0]           DEFAULT_RD_DATA = DATA_W'(32'hDEADBEEF),
  parameter logic                        ENDIAN_LITTLE   = 1'b0,
  parameter int                          TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk_74a,
  input  logic                         reset_n,
  bridge_router_pipe_if.slave          br,
  output logic                         rd_busy,
  output logic [ADDR_W-1:0]            leaf_addr,
  output logic [DATA_W-1:0]            leaf_wr_data,
  output logic [NUM_LEAVES-1:0]        leaf_wr,
  output logic [NUM_LEAVES-1:0]        leaf_rd,
  input  logic [NUM_LEAVES*DATA_W-1:0] leaf_rd_data,
  input  logic [NUM_LEAVES-1:0]        leaf_rd_valid,
  output logic [7:0]                   miss_count,
  output logic                         overrun,
  output logic [7:0]                   timeout_count
);
  localparam int SEL_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

  if (NUM_LEAVES < 1 || NUM_LEAVES > MAX_LEAVES || ADDR_W > MAX_ADDR_W ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("bridge_router_pipe: parameter out of supported range");
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              hit;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_p1;
  rd_state_e         state_p1, state_d;
  logic              rd_take, rd_drop, wr_miss, rd_miss, rd_ret, rd_tmo;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wr_data_p1, rd_data_p1;
  logic [NUM_LEAVES-1:0] wr_p1, rd_p1;
  logic [7:0]        miss_p1;
  logic              overrun_p1;
  logic [DATA_W-1:0] leaf_rd_arr [NUM_LEAVES];

  for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_rd_slice
    assign leaf_rd_arr[g] = leaf_rd_data[g*DATA_W +: DATA_W];
  end

  bridge_range_decode #(
    .NUM_LEAVES (NUM_LEAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .FROM_ADDRS (FROM_ADDRS),
    .TO_ADDRS   (TO_ADDRS)
  ) u_decode (
    .addr (br.bridge_addr),
    .hit  (hit),
    .sel  (sel)
  );

`ifdef BRIDGE_ROUTER_TIMEOUT_EN
  logic [15:0] wdog_p1;
  logic [7:0]  tmo_p1;
`endif

  // Read FSM decisions: a write in the same cycle or a busy FSM drops the read.
  always_comb begin
    rd_take = br.bridge_rd && !br.bridge_wr && (state_p1 == IDLE);
    rd_drop = br.bridge_rd && !rd_take;
    wr_miss = br.bridge_wr && !hit;
    rd_miss = rd_take && !hit;
    rd_ret  = (state_p1 == RD_WAIT) && leaf_rd_valid[sel_p1];
    rd_tmo  = 1'b0;
`ifdef BRIDGE_ROUTER_TIMEOUT_EN
    rd_tmo  = (state_p1 == RD_WAIT) && !rd_ret && (wdog_p1 == 16'(TIMEOUT_CYCLES - 1));
`endif
    state_d = state_p1;
    case (state_p1)
      IDLE:    if (rd_take && hit) state_d = RD_WAIT;
      RD_WAIT: if (rd_ret || rd_tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) state_p1 <= IDLE;
    else          state_p1 <= state_d;
  end

  // Stage p1: registered leaf strobes, shared address/data, read capture and counters.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      addr_p1    <= '0;
      wr_data_p1 <= '0;
      wr_p1      <= '0;
      rd_p1      <= '0;
      sel_p1     <= '0;
      rd_data_p1 <= '0;
      miss_p1    <= '0;
      overrun_p1 <= 1'b0;
    end else begin
      wr_p1 <= '0;
      rd_p1 <= '0;
      if (br.bridge_wr || br.bridge_rd) begin
        addr_p1    <= br.bridge_addr;
        wr_data_p1 <= br.bridge_wr_data;
      end
      if (br.bridge_wr && hit) wr_p1[sel] <= 1'b1;
      if (rd_take && hit) begin
        rd_p1[sel] <= 1'b1;
        sel_p1     <= sel;
      end
      if (rd_miss || rd_tmo) rd_data_p1 <= DEFAULT_RD_DATA;
      else if (rd_ret)       rd_data_p1 <= leaf_rd_arr[sel_p1];
      if (wr_miss || rd_miss) miss_p1 <= sat_inc(miss_p1);
      if (rd_drop)            overrun_p1 <= 1'b1;
    end
  end

`ifdef BRIDGE_ROUTER_TIMEOUT_EN
  // Watchdog counts completed RD_WAIT cycles; IDLE holds it at zero for the next entry.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wdog_p1 <= '0;
      tmo_p1  <= '0;
    end else begin
      wdog_p1 <= (state_p1 == IDLE) ? 16'd0 : wdog_p1 + 16'd1;
      if (rd_tmo) tmo_p1 <= sat_inc(tmo_p1);
    end
  end
  assign timeout_count = tmo_p1;
`else
  assign timeout_count = 8'd0;
`endif

  assign rd_busy                 = (state_p1 == RD_WAIT);
  assign leaf_addr               = addr_p1;
  assign leaf_wr_data            = wr_data_p1;
  assign leaf_wr                 = wr_p1;
  assign leaf_rd                 = rd_p1;
  assign miss_count              = miss_p1;
  assign overrun                 = overrun_p1;
  assign br.bridge_rd_data       = rd_data_p1;
  assign br.bridge_endian_little = ENDIAN_LITTLE;
endmodule

// File: tb/tb_bridge_router_pipe.sv
// Self-checking bench for bridge_router_pipe: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honors BRIDGE_ROUTER_TIMEOUT_EN.
module tb_bridge_router_pipe;
  localparam int          NL  = 2;
  localparam logic [31:0] DEF = 32'hDEADBEEF;
  localparam int          TMO = 16;
  localparam logic [31:0] R_FROM [NL] = '{32'h0000_0000, 32'hF800_0000};
  localparam logic [31:0] R_TO   [NL] = '{32'h000F_FFFF, 32'hF800_1FFF};

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b1;
  logic        rd_busy;
  logic [31:0] leaf_addr, leaf_wr_data;
  logic [1:0]  leaf_wr, leaf_rd, leaf_rd_valid;
  logic [63:0] leaf_rd_data;
  logic [7:0]  miss_count, timeout_count;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0]  m_wr, m_rd;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_miss, m_tmo, m_pend, m_wait;
  bit          m_over, m_busy;

  bridge_router_pipe_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bridge_router_pipe #(
    .NUM_LEAVES      (NL),
    .ADDR_W          (32),
    .DATA_W          (32),
    .FROM_ADDRS      ({32'hF800_0000, 32'h0000_0000}),
    .TO_ADDRS        ({32'hF800_1FFF, 32'h000F_FFFF}),
    .DEFAULT_RD_DATA (DEF),
    .ENDIAN_LITTLE   (1'b0),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .br            (bif),
    .rd_busy       (rd_busy),
    .leaf_addr     (leaf_addr),
    .leaf_wr_data  (leaf_wr_data),
    .leaf_wr       (leaf_wr),
    .leaf_rd       (leaf_rd),
    .leaf_rd_data  (leaf_rd_data),
    .leaf_rd_valid (leaf_rd_valid),
    .miss_count    (miss_count),
    .overrun       (overrun),
    .timeout_count (timeout_count)
  );

  always #5 clk_74a = ~clk_74a;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout sim time exceeded, required finish earlier");
    $fatal(1, "bench time limit");
  end

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NL; i++)
      if (a >= R_FROM[i] && a <= R_TO[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [6];
    edges = '{32'h000F_FFFF, 32'h0010_0000, 32'hF7FF_FFFF, 32'hF800_1FFF, 32'hF800_2000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 5))
      0, 1:    return $urandom_range(0, 32'h000F_FFFF);
      2, 3:    return 32'hF800_0000 + $urandom_range(0, 32'h1FFF);
      4:       return edges[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_wr = '0; m_rd = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_miss = 0; m_tmo = 0; m_pend = 0; m_wait = 0; m_over = 0; m_busy = 0;
  endtask

  // Applies the routing rules to the inputs present just before a clock edge.
  task automatic model_edge();
    int d;
    bit was_busy;
    was_busy = m_busy;
    d = ref_decode(bif.bridge_addr);
    m_wr = '0;
    m_rd = '0;
    if (bif.bridge_wr || bif.bridge_rd) begin
      m_addr  = bif.bridge_addr;
      m_wdata = bif.bridge_wr_data;
    end
    if (bif.bridge_wr) begin
      if (d >= 0) m_wr[d] = 1'b1;
      else if (m_miss < 255) m_miss++;
    end
    if (was_busy) begin
      m_wait++;
      if (leaf_rd_valid[m_pend]) begin
        m_rdata = 32'(leaf_rd_data >> (m_pend * 32));
        m_busy  = 0;
      end
`ifdef BRIDGE_ROUTER_TIMEOUT_EN
      else if (m_wait == TMO) begin
        m_rdata = DEF;
        m_busy  = 0;
        if (m_tmo < 255) m_tmo++;
      end
`endif
    end
    if (bif.bridge_rd) begin
      if (bif.bridge_wr || was_busy) m_over = 1;
      else if (d >= 0) begin
        m_rd[d] = 1'b1;
        m_busy  = 1;
        m_pend  = d;
        m_wait  = 0;
      end else begin
        m_rdata = DEF;
        if (m_miss < 255) m_miss++;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic idle_inputs();
    bif.bridge_wr = 1'b0;
    bif.bridge_rd = 1'b0;
    leaf_rd_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bif.bridge_addr    = '0;
    bif.bridge_wr_data = '0;
    leaf_rd_data       = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_74a);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (leaf_wr !== 2'b00 || leaf_rd !== 2'b00) begin n_err++; $display("FAIL reset_pulses got wr=%b rd=%b want 00/00", leaf_wr, leaf_rd); end
    n_cmp++; if (leaf_addr !== 32'h0 || leaf_wr_data !== 32'h0) begin n_err++; $display("FAIL reset_leaf_bus got %h/%h want 0/0", leaf_addr, leaf_wr_data); end
    n_cmp++; if (bif.bridge_rd_data !== 32'h0 || rd_busy !== 1'b0) begin n_err++; $display("FAIL reset_rd got data=%h busy=%b want 0/0", bif.bridge_rd_data, rd_busy); end
    n_cmp++; if (miss_count !== 8'h0 || overrun !== 1'b0 || timeout_count !== 8'h0) begin n_err++; $display("FAIL reset_status got miss=%h ovr=%b tmo=%h want 0", miss_count, overrun, timeout_count); end
    n_cmp++; if (bif.bridge_endian_little !== 1'b0) begin n_err++; $display("FAIL reset_endian got %b want 0", bif.bridge_endian_little); end
  endtask

  task automatic test_write();
    do_reset();
    bif.bridge_addr = 32'hF800_0010; bif.bridge_wr_data = 32'h1234_5678; bif.bridge_wr = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (leaf_wr !== 2'b10) begin n_err++; $display("FAIL write_pulse got %b want 10", leaf_wr); end
    n_cmp++; if (leaf_wr_data !== 32'h1234_5678 || leaf_addr !== 32'hF800_0010) begin n_err++; $display("FAIL write_bus got %h@%h want 12345678@f8000010", leaf_wr_data, leaf_addr); end
    n_cmp++; if (miss_count !== 8'h0) begin n_err++; $display("FAIL write_miss got %h want 0", miss_count); end
    tick();
    n_cmp++; if (leaf_wr !== 2'b00 || leaf_addr !== 32'hF800_0010) begin n_err++; $display("FAIL write_one_cycle got wr=%b addr=%h want 00/f8000010", leaf_wr, leaf_addr); end
  endtask

  task automatic test_read_leaf();
    int busy_n;
    do_reset();
    busy_n = 0;
    bif.bridge_addr = 32'h0000_0040; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (leaf_rd !== 2'b01) begin n_err++; $display("FAIL read_pulse got %b want 01", leaf_rd); end
    if (rd_busy) busy_n++;
    tick();
    if (rd_busy) busy_n++;
    tick();
    if (rd_busy) busy_n++;
    leaf_rd_valid = 2'b01; leaf_rd_data = {32'h0, 32'hAABB_CCDD};
    tick();
    idle_inputs();
    if (rd_busy) busy_n++;
    n_cmp++; if (busy_n !== 3) begin n_err++; $display("FAIL read_busy_len got %0d want 3", busy_n); end
    n_cmp++; if (bif.bridge_rd_data !== 32'hAABB_CCDD) begin n_err++; $display("FAIL read_data got %h want aabbccdd", bif.bridge_rd_data); end
  endtask

  task automatic test_unmapped();
    do_reset();
    bif.bridge_addr = 32'h2000_0000; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (leaf_rd !== 2'b00 || rd_busy !== 1'b0) begin n_err++; $display("FAIL unmapped_rd got rd=%b busy=%b want 00/0", leaf_rd, rd_busy); end
    n_cmp++; if (bif.bridge_rd_data !== DEF) begin n_err++; $display("FAIL unmapped_data got %h want deadbeef", bif.bridge_rd_data); end
    n_cmp++; if (miss_count !== 8'd1) begin n_err++; $display("FAIL unmapped_miss got %h want 01", miss_count); end
    for (int i = 0; i < 300; i++) begin
      bif.bridge_addr = 32'h2000_0000 + 32'(i); bif.bridge_wr = 1'b1;
      tick();
    end
    idle_inputs();
    n_cmp++; if (leaf_wr !== 2'b00) begin n_err++; $display("FAIL unmapped_wr got %b want 00", leaf_wr); end
    n_cmp++; if (miss_count !== 8'hFF) begin n_err++; $display("FAIL miss_saturate got %h want ff", miss_count); end
  endtask

  task automatic test_wrong_leaf();
    do_reset();
    bif.bridge_addr = 32'h0000_0100; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    leaf_rd_valid = 2'b10; leaf_rd_data = {32'h1111_1111, 32'h0};
    tick();
    idle_inputs();
    n_cmp++; if (rd_busy !== 1'b1 || bif.bridge_rd_data !== 32'h0) begin n_err++; $display("FAIL other_leaf_ignored got busy=%b data=%h want 1/0", rd_busy, bif.bridge_rd_data); end
    bif.bridge_addr = 32'h0000_0200; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (leaf_rd !== 2'b00 || overrun !== 1'b1) begin n_err++; $display("FAIL overrun_drop got rd=%b ovr=%b want 00/1", leaf_rd, overrun); end
    leaf_rd_valid = 2'b01; leaf_rd_data = {32'h1111_1111, 32'h2222_2222};
    tick();
    idle_inputs();
    n_cmp++; if (bif.bridge_rd_data !== 32'h2222_2222 || rd_busy !== 1'b0) begin n_err++; $display("FAIL sel_leaf_data got %h busy=%b want 22222222/0", bif.bridge_rd_data, rd_busy); end
  endtask

  task automatic test_conflict();
    do_reset();
    bif.bridge_addr = 32'h0000_0010; bif.bridge_wr_data = 32'h0000_CAFE;
    bif.bridge_wr = 1'b1; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (leaf_wr !== 2'b01 || leaf_rd !== 2'b00) begin n_err++; $display("FAIL conflict_pulses got wr=%b rd=%b want 01/00", leaf_wr, leaf_rd); end
    n_cmp++; if (overrun !== 1'b1 || rd_busy !== 1'b0) begin n_err++; $display("FAIL conflict_ovr got ovr=%b busy=%b want 1/0", overrun, rd_busy); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bif.bridge_addr = 32'h0000_0040; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    tick();
    n_cmp++; if (rd_busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got %b want 1", rd_busy); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (rd_busy !== 1'b0 || leaf_addr !== 32'h0 || bif.bridge_rd_data !== 32'h0) begin n_err++; $display("FAIL async_reset got busy=%b addr=%h data=%h want 0", rd_busy, leaf_addr, bif.bridge_rd_data); end
    @(posedge clk_74a);
    #1 reset_n = 1'b1;
    leaf_rd_valid = 2'b01; leaf_rd_data = {32'h0, 32'h5555_5555};
    tick();
    idle_inputs();
    n_cmp++; if (bif.bridge_rd_data !== 32'h0 || rd_busy !== 1'b0) begin n_err++; $display("FAIL late_valid got data=%h busy=%b want 0/0", bif.bridge_rd_data, rd_busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    bif.bridge_addr = 32'hF800_0000; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
`ifdef BRIDGE_ROUTER_TIMEOUT_EN
    repeat (15) tick();
    n_cmp++; if (rd_busy !== 1'b1 || bif.bridge_rd_data !== 32'h0) begin n_err++; $display("FAIL tmo_wait got busy=%b data=%h want 1/0", rd_busy, bif.bridge_rd_data); end
    tick();
    n_cmp++; if (bif.bridge_rd_data !== DEF || timeout_count !== 8'd1 || rd_busy !== 1'b0) begin n_err++; $display("FAIL tmo_fire got data=%h cnt=%h busy=%b want deadbeef/01/0", bif.bridge_rd_data, timeout_count, rd_busy); end
    bif.bridge_addr = 32'hF800_0004; bif.bridge_rd = 1'b1;
    tick();
    idle_inputs();
    repeat (15) tick();
    leaf_rd_valid = 2'b10; leaf_rd_data = {32'h7777_0000, 32'h0};
    tick();
    idle_inputs();
    n_cmp++; if (bif.bridge_rd_data !== 32'h7777_0000 || timeout_count !== 8'd1) begin n_err++; $display("FAIL tmo_valid_wins got data=%h cnt=%h want 77770000/01", bif.bridge_rd_data, timeout_count); end
`else
    repeat (40) tick();
    n_cmp++; if (rd_busy !== 1'b1 || timeout_count !== 8'd0) begin n_err++; $display("FAIL no_watchdog got busy=%b cnt=%h want 1/00", rd_busy, timeout_count); end
    leaf_rd_valid = 2'b10; leaf_rd_data = {32'h7777_0000, 32'h0};
    tick();
    idle_inputs();
    n_cmp++; if (bif.bridge_rd_data !== 32'h7777_0000 || rd_busy !== 1'b0) begin n_err++; $display("FAIL long_wait_data got %h busy=%b want 77770000/0", bif.bridge_rd_data, rd_busy); end
`endif
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op = $urandom_range(0, 9);
      bif.bridge_addr    = pick_addr();
      bif.bridge_wr_data = $urandom;
      bif.bridge_wr      = (op <= 2 || op == 6);
      bif.bridge_rd      = ((op >= 3 && op <= 5) || op == 6);
      leaf_rd_valid      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      leaf_rd_data       = {$urandom, $urandom};
      tick();
      n_cmp++; if (leaf_wr !== m_wr || leaf_rd !== m_rd) begin n_err++; $display("FAIL rnd_pulses c=%0d got wr=%b rd=%b want %b/%b", c, leaf_wr, leaf_rd, m_wr, m_rd); end
      n_cmp++; if (leaf_addr !== m_addr || leaf_wr_data !== m_wdata) begin n_err++; $display("FAIL rnd_bus c=%0d got %h/%h want %h/%h", c, leaf_addr, leaf_wr_data, m_addr, m_wdata); end
      n_cmp++; if (bif.bridge_rd_data !== m_rdata || rd_busy !== m_busy) begin n_err++; $display("FAIL rnd_rd c=%0d got %h busy=%b want %h/%b", c, bif.bridge_rd_data, rd_busy, m_rdata, m_busy); end
      n_cmp++; if (miss_count !== 8'(m_miss) || overrun !== m_over || timeout_count !== 8'(m_tmo)) begin n_err++; $display("FAIL rnd_status c=%0d got %h/%b/%h want %h/%b/%h", c, miss_count, overrun, timeout_count, 8'(m_miss), m_over, 8'(m_tmo)); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bif.bridge_addr    = '0;
    bif.bridge_wr_data = '0;
    leaf_rd_data       = '0;
    model_reset();
    #1;
    test_reset();
    test_write();
    test_read_leaf();
    test_unmapped();
    test_wrong_leaf();
    test_conflict();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
